// File: rtl/preg_free_list.sv
// -----------------------------------------------------------------------------
// preg_free_list
//   Circular FIFO of unallocated physical register tags feeding rename.
//   Rename pops at most one tag per cycle. Retirement returns up to two tags
//   per cycle, slot 0 first. Tag 0 is permanently bound to x0, so freeing it
//   has no effect. A push that arrives while the list is full is dropped and
//   sets a sticky error flag.
//
//   Optional feature (macro FREE_LIST_CKPT_EN): a single head-pointer
//   checkpoint with save/restore controls, used for rename recovery.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   alloc_req     in   rename consumes the head tag this cycle
//   alloc_valid   out  list non-empty, alloc_tag is valid
//   alloc_tag     out  head tag (combinational from head pointer)
//   free0_valid   in   retire slot 0 returns free0_tag
//   free0_tag     in   tag returned by slot 0
//   free1_valid   in   retire slot 1 returns free1_tag
//   free1_tag     in   tag returned by slot 1
//   free_count    out  number of free tags, 0..FL_DEPTH
//   overflow_err  out  sticky, a push was dropped because the list was full
//   ckpt_save     in   (FREE_LIST_CKPT_EN) capture post-pop head
//   ckpt_restore  in   (FREE_LIST_CKPT_EN) reload head from checkpoint
// -----------------------------------------------------------------------------
module preg_free_list #(
  parameter int PREG_WIDTH = 6,
  parameter int NUM_PREG   = 64,
  parameter int NUM_AREG   = 32,
  parameter int FL_DEPTH   = 32,
  parameter int PTR_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  output logic                  alloc_valid,
  output logic [PREG_WIDTH-1:0] alloc_tag,
  input  logic                  free0_valid,
  input  logic [PREG_WIDTH-1:0] free0_tag,
  input  logic                  free1_valid,
  input  logic [PREG_WIDTH-1:0] free1_tag,
  output logic [PTR_WIDTH-1:0]  free_count,
  output logic                  overflow_err
`ifdef FREE_LIST_CKPT_EN
  ,
  input  logic                  ckpt_save,
  input  logic                  ckpt_restore
`endif
);

  localparam int IDX_W = PTR_WIDTH - 1;
  localparam logic [PTR_WIDTH-1:0] FULL_CNT = PTR_WIDTH'(FL_DEPTH);

  // Configuration sanity: the list must hold exactly the unmapped registers,
  // and the pointer must be one bit wider than the index.
  if (FL_DEPTH != NUM_PREG - NUM_AREG || (1 << IDX_W) != FL_DEPTH) begin : g_bad_cfg
    $error("preg_free_list: inconsistent FL_DEPTH/NUM_PREG/NUM_AREG/PTR_WIDTH");
  end

  logic [PREG_WIDTH-1:0] entry_q [FL_DEPTH];
  logic [PTR_WIDTH-1:0]  head_q, head_d;
  logic [PTR_WIDTH-1:0]  tail_q, tail_d;
  logic                  ovf_q, ovf_d;

  logic                  pop;
  logic                  req0, req1, acc0, acc1;
  logic [PTR_WIDTH-1:0]  count, count_after0;
  logic [PTR_WIDTH-1:0]  head_pop;
  logic                  wr0_en, wr1_en;
  logic [IDX_W-1:0]      wr0_idx, wr1_idx;
  logic [PREG_WIDTH-1:0] wr0_tag;

`ifdef FREE_LIST_CKPT_EN
  logic [PTR_WIDTH-1:0]  ckpt_q, ckpt_d;
`endif

  // Wrap bit distinguishes full (difference FL_DEPTH) from empty (0).
  assign count       = tail_q - head_q;
  assign free_count  = count;
  assign alloc_valid = (count != '0);
  assign alloc_tag   = entry_q[head_q[IDX_W-1:0]];
  assign overflow_err = ovf_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pop          = alloc_req && alloc_valid;
    head_pop     = head_q + PTR_WIDTH'(pop);
    head_d       = head_pop;

    // Full check ignores this cycle's pop; slot 1 sees slot 0's push.
    req0         = free0_valid && (free0_tag != '0);
    acc0         = req0 && (count != FULL_CNT);
    count_after0 = count + PTR_WIDTH'(acc0);
    req1         = free1_valid && (free1_tag != '0);
    acc1         = req1 && (count_after0 != FULL_CNT);

    tail_d       = tail_q + PTR_WIDTH'(acc0) + PTR_WIDTH'(acc1);
    ovf_d        = ovf_q | (req0 & ~acc0) | (req1 & ~acc1);

    // First accepted push lands at tail; a second one at tail+1.
    wr0_en       = acc0 | acc1;
    wr0_idx      = tail_q[IDX_W-1:0];
    wr0_tag      = acc0 ? free0_tag : free1_tag;
    wr1_en       = acc0 & acc1;
    wr1_idx      = wr0_idx + IDX_W'(1);

`ifdef FREE_LIST_CKPT_EN
    ckpt_d = ckpt_q;
    if (ckpt_restore) begin
      head_d = ckpt_q;
    end else if (ckpt_save) begin
      ckpt_d = head_pop;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= FULL_CNT;
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ovf_q  <= ovf_d;
    end
  end

  // NOTE: this storage is reset on purpose; at power-up it must already hold
  // the unmapped tags NUM_AREG..NUM_PREG-1, so it cannot be left as plain RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        entry_q[i] <= PREG_WIDTH'(NUM_AREG + i);
      end
    end else begin
      if (wr0_en) entry_q[wr0_idx] <= wr0_tag;
      if (wr1_en) entry_q[wr1_idx] <= free1_tag;
    end
  end

`ifdef FREE_LIST_CKPT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ckpt_q <= '0;
    end else begin
      ckpt_q <= ckpt_d;
    end
  end
`endif

endmodule

// File: tb/tb_preg_free_list.sv
// -----------------------------------------------------------------------------
// tb_preg_free_list
//   Self-checking bench for preg_free_list. A queue scoreboard holds the tags
//   expected at the head of the list; pushes append, pops compare and remove.
//   Define FREE_LIST_CKPT_EN to also exercise the checkpoint ports.
// -----------------------------------------------------------------------------
module tb_preg_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req;
  logic       alloc_valid;
  logic [5:0] alloc_tag;
  logic       free0_valid, free1_valid;
  logic [5:0] free0_tag, free1_tag;
  logic [5:0] free_count;
  logic       overflow_err;
`ifdef FREE_LIST_CKPT_EN
  logic       ckpt_save, ckpt_restore;
`endif

  preg_free_list dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_valid  (alloc_valid),
    .alloc_tag    (alloc_tag),
    .free0_valid  (free0_valid),
    .free0_tag    (free0_tag),
    .free1_valid  (free1_valid),
    .free1_tag    (free1_tag),
    .free_count   (free_count),
    .overflow_err (overflow_err)
`ifdef FREE_LIST_CKPT_EN
    ,
    .ckpt_save    (ckpt_save),
    .ckpt_restore (ckpt_restore)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];   // expected list contents, head first
  logic [5:0] snap_q[$];  // expected contents from checkpoint head to tail
  bit         snap_live;
  bit         exp_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(6'(32 + i));
    snap_q.delete();
    snap_live = 0;
    exp_ovf   = 0;
  endtask

  task automatic drive_idle();
    alloc_req   = 1'b0;
    free0_valid = 1'b0;
    free0_tag   = '0;
    free1_valid = 1'b0;
    free1_tag   = '0;
`ifdef FREE_LIST_CKPT_EN
    ckpt_save    = 1'b0;
    ckpt_restore = 1'b0;
`endif
  endtask

  // Called at posedge+1: drive inputs, check current outputs against the
  // scoreboard, advance the model, then move to the next posedge+1.
  task automatic step(input bit req, input bit v0, input logic [5:0] t0,
                      input bit v1, input logic [5:0] t1,
                      input bit sv = 0, input bit rs = 0);
    int  n, cnt;
    bit  pop, r0, r1, a0, a1;
    alloc_req   = req;
    free0_valid = v0;
    free0_tag   = t0;
    free1_valid = v1;
    free1_tag   = t1;
`ifdef FREE_LIST_CKPT_EN
    ckpt_save    = sv;
    ckpt_restore = rs;
`endif
    #1;
    n = exp_q.size();
    check("alloc_valid", 32'(alloc_valid), 32'(n != 0));
    check("free_count", 32'(free_count), 32'(n));
    if (n != 0) check("alloc_tag", 32'(alloc_tag), 32'(exp_q[0]));
    check("overflow_err", 32'(overflow_err), 32'(exp_ovf));

    pop = req && (n != 0);
    r0  = v0 && (t0 != 0);
    a0  = r0 && (n < 32);
    cnt = n + int'(a0);
    r1  = v1 && (t1 != 0);
    a1  = r1 && (cnt < 32);
    if ((r0 && !a0) || (r1 && !a1)) exp_ovf = 1;

    if (rs) exp_q = snap_q;
    else if (pop) void'(exp_q.pop_front());
    if (sv && !rs) begin
      snap_q    = exp_q;
      snap_live = 1;
    end
    if (a0) begin
      exp_q.push_back(t0);
      if (snap_live) snap_q.push_back(t0);
    end
    if (a1) begin
      exp_q.push_back(t1);
      if (snap_live) snap_q.push_back(t1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b0;
    model_reset();
    #3;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive_idle();
    rst = 1'b0;
    model_reset();
    #12;
    check("rst_count", 32'(free_count), 32);
    check("rst_valid", 32'(alloc_valid), 1);
    check("rst_tag", 32'(alloc_tag), 32);
    check("rst_ovf", 32'(overflow_err), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Drain all 32 reset tags in order, then pop while empty.
    for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 0);
    check("empty_count", 32'(free_count), 0);
    check("empty_valid", 32'(alloc_valid), 0);
    step(1, 0, 0, 0, 0);
    check("empty_pop_count", 32'(free_count), 0);

    // Dual push into empty list: not visible until next cycle.
    step(0, 1, 6'd40, 1, 6'd41);
    check("dual_count", 32'(free_count), 2);
    check("dual_tag0", 32'(alloc_tag), 40);
    step(1, 0, 0, 0, 0);
    check("dual_tag1", 32'(alloc_tag), 41);

    // Tag 0 is dropped silently, tag 7 accepted.
    step(0, 1, 6'd0, 1, 6'd7);
    check("tag0_count", 32'(free_count), 2);
    check("tag0_ovf", 32'(overflow_err), 0);

    // Fill to 31, then pop + two frees: only the first fits.
    while (exp_q.size() < 31) step(0, 1, 6'(9 + exp_q.size()), 0, 0);
    step(1, 1, 6'd5, 1, 6'd6);
    check("ovf_count", 32'(free_count), 31);
    check("ovf_set", 32'(overflow_err), 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    check("ovf_sticky", 32'(overflow_err), 1);
    for (int i = 0; i < 30; i++) step(1, 0, 0, 0, 0);

    // Asynchronous reset mid-operation, checked before any clock edge.
    alloc_req   = 1'b1;
    free0_valid = 1'b1;
    free0_tag   = 6'd9;
    #3;
    rst = 1'b0;
    #1;
    check("arst_count", 32'(free_count), 32);
    check("arst_valid", 32'(alloc_valid), 1);
    check("arst_tag", 32'(alloc_tag), 32);
    check("arst_ovf", 32'(overflow_err), 0);
    do_reset();

    // Random traffic: wraps pointers, fills and overflows repeatedly.
    for (int i = 0; i < 600; i++) begin
      step(bit'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 4), 6'($urandom_range(0, 63)),
           ($urandom_range(0, 9) < 4), 6'($urandom_range(0, 63)));
    end
    step(0, 0, 0, 0, 0);

`ifdef FREE_LIST_CKPT_EN
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    check("ckpt_pre_count", 32'(free_count), 25);
    step(1, 0, 0, 0, 0, 0, 1);
    check("ckpt_tag", 32'(alloc_tag), 35);
    check("ckpt_count", 32'(free_count), 29);
    // Save and restore together: restore wins, checkpoint kept.
    step(1, 0, 0, 0, 0, 1, 1);
    check("ckpt_both_tag", 32'(alloc_tag), 35);
    step(0, 0, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
